aurora_tx_block_scheduler: RTL

Shares the 4-lane Aurora 64b/66b TX block slot between the multilane data-frame FSM and the service-frame (register readback) source, and fills empty slots with idle. Each TX slot it picks one 256-bit block (data, service or idle) using a programmable service-skip policy, stages it in an output register for the lane encoders, and returns one-cycle acknowledge pulses to the winning requester. It sits between the data-frame FSM / service-frame builder and the per-lane scrambler/gearbox.

---
 rtl/aurora_tx_block_scheduler.sv | 77 +++++++
 1 files changed

// File: rtl/aurora_tx_block_scheduler.sv
// aurora_tx_block_scheduler: picks data, service or idle for each 4-lane TX slot and stages it for the lane encoders
module aurora_tx_block_scheduler #(
    parameter int SKIP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lane_ready,
    input  logic              tx_slot,
    input  logic              data_send_block,
    input  logic [255:0]      data_to_send,
    input  logic [15:0]       data_bytes_to_send,
    input  logic              service_req,
    input  logic [255:0]      service_data,
    input  logic [SKIP_W-1:0] service_skip,
    output logic              block_sent,
    output logic              service_ack,
    output logic [1:0]        tx_kind,
    output logic [255:0]      tx_data,
    output logic [15:0]       tx_bytes,
    output logic [CNT_W-1:0]  data_block_cnt,
    output logic [CNT_W-1:0]  service_block_cnt,
    output logic [CNT_W-1:0]  idle_block_cnt
);
    logic [SKIP_W-1:0] since_service;
    logic [SKIP_W-1:0] since_inc;
    logic              dreq;
    logic              sreq;
    logic              pick_service;
    logic              pick_data;

    // Effective requests hide each requester's stale request during its own ack cycle
    always_comb begin
        dreq         = data_send_block & ~block_sent;
        sreq         = service_req & ~service_ack;
        pick_service = sreq & ((since_service >= service_skip) | ~dreq);
        pick_data    = ~pick_service & dreq;
        since_inc    = (since_service == '1) ? since_service : since_service + 1'b1;
    end

    // Staging register, ack pulses, skip counter and block counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_kind           <= 2'b00;
            tx_data           <= '0;
            tx_bytes          <= '0;
            block_sent        <= 1'b0;
            service_ack       <= 1'b0;
            since_service     <= '1;
            data_block_cnt    <= '0;
            service_block_cnt <= '0;
            idle_block_cnt    <= '0;
        end else if (!lane_ready) begin
            tx_kind       <= 2'b00;
            tx_data       <= '0;
            tx_bytes      <= '0;
            block_sent    <= 1'b0;
            service_ack   <= 1'b0;
            since_service <= '1;
        end else begin
            block_sent  <= tx_slot & pick_data;
            service_ack <= tx_slot & pick_service;
            if (tx_slot) begin
                tx_kind       <= pick_service ? 2'b10 : pick_data ? 2'b01 : 2'b00;
                tx_data       <= pick_service ? service_data : pick_data ? data_to_send : '0;
                tx_bytes      <= pick_service ? 16'hFFFF : pick_data ? data_bytes_to_send : 16'h0000;
                since_service <= pick_service ? '0 : since_inc;
                if (pick_service)
                    service_block_cnt <= service_block_cnt + 1'b1;
                else if (pick_data)
                    data_block_cnt <= data_block_cnt + 1'b1;
                else
                    idle_block_cnt <= idle_block_cnt + 1'b1;
            end
        end
    end
endmodule
